// File: rtl/adder_sequencer.sv
// -----------------------------------------------------------------------------
// adder_sequencer
//
// Sequences one operation at a time through an external combinational full
// adder. An operand set is accepted in IDLE, presented to the adder during
// CALC, and the registered result (sum, carry-out, zero and two's-complement
// overflow flags) is offered in DONE until the consumer takes it. Accumulate
// mode reuses the previous sum and carry-out as operand A and carry-in.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Ready never depends on valid on the same side. The producer must
// hold its data stable while valid=1 and ready=0, and the block holds its
// result stable while out_valid=1 and out_ready=0.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      operand-set handshake
//   in_a, in_b, in_cin     operands and carry-in
//   in_acc                 accumulate: A <- last sum, cin <- last carry-out
//   add_a/add_b/add_cin    operands driven to the external adder
//   add_sum/add_cout       combinational result from the external adder
//   out_valid/out_ready    result handshake
//   out_sum, out_cout      registered result
//   out_zero, out_ovf      registered zero and signed-overflow flags
//   dbg_state              current FSM state (0=IDLE, 1=CALC, 2=DONE)
// -----------------------------------------------------------------------------
module adder_sequencer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_acc,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_cin,
    input  logic [N-1:0] add_sum,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_cout,
    output logic         out_zero,
    output logic         out_ovf,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   op_a_q, op_a_d;
    logic [N-1:0]   op_b_q, op_b_d;
    logic           op_cin_q, op_cin_d;
    logic [N-1:0]   out_sum_q, out_sum_d;
    logic           out_cout_q, out_cout_d;
    logic           out_zero_q, out_zero_d;
    logic           out_ovf_q, out_ovf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_cin_q   <= 1'b0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_zero_q <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_cin_q   <= op_cin_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
            out_zero_q <= out_zero_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_cin_d   = op_cin_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        out_zero_d = out_zero_q;
        out_ovf_d  = out_ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Accumulate chains off the result registers, which are
                    // left untouched when DONE exits for exactly this purpose.
                    op_a_d   = in_acc ? out_sum_q : in_a;
                    op_b_d   = in_b;
                    op_cin_d = in_acc ? out_cout_q : in_cin;
                    state_d  = CALC;
                end
            end
            CALC: begin
                out_sum_d  = add_sum;
                out_cout_d = add_cout;
                out_zero_d = (add_sum == '0);
                // Signed overflow: like-signed operands giving an
                // opposite-signed sum.
                out_ovf_d  = (op_a_q[N-1] == op_b_q[N-1]) &&
                             (add_sum[N-1] != op_a_q[N-1]);
                state_d    = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State is already IDLE during reset; gating with rst_n keeps in_ready
    // low for the whole reset period.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign add_a     = op_a_q;
    assign add_b     = op_b_q;
    assign add_cin   = op_cin_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_zero  = out_zero_q;
    assign out_ovf   = out_ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_adder_sequencer.sv
module tb_adder_sequencer;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, in_cin, in_acc;
  logic [N-1:0] in_a, in_b;
  logic [N-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid, out_ready, out_cout, out_zero, out_ovf;
  logic [N-1:0] out_sum;
  logic [1:0]   dbg_state;

  // external full adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  adder_sequencer #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_acc(in_acc),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .out_zero(out_zero), .out_ovf(out_ovf),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  // expected {ovf, zero, cout, sum}
  logic [N+2:0] exp_q[$];

  // reference state: last delivered result
  int last_sum  = 0;
  int last_cout = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= (1 << (N - 1))) ? v - (1 << N) : v;
  endfunction

  // ---------------- driver ----------------
  task automatic do_op(input int a, input int b, input int cin, input int acc, input int hold);
    int ea, ecin, total, esum, ecout, sv, eovf;
    logic [N+2:0] exp;
    logic [N-1:0] snap_sum;
    ea    = acc ? last_sum : a;
    ecin  = acc ? last_cout : cin;
    total = ea + b + ecin;
    esum  = total % (1 << N);
    ecout = (total >= (1 << N)) ? 1 : 0;
    sv    = to_signed(ea) + to_signed(b) + ecin;
    eovf  = (sv > (1 << (N - 1)) - 1 || sv < -(1 << (N - 1))) ? 1 : 0;
    exp   = {eovf[0], (esum == 0), ecout[0], esum[N-1:0]};
    exp_q.push_back(exp);

    @(negedge clk);
    check("idle_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_a      = a[N-1:0];
    in_b      = b[N-1:0];
    in_cin    = cin[0];
    in_acc    = acc[0];
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = N'($urandom);
    in_cin   = 1'($urandom);
    check("calc_ready", in_ready, 0);
    check("calc_valid", out_valid, 0);
    check("add_a", add_a, ea);
    check("add_b", add_b, b);
    check("add_cin", add_cin, ecin);
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    check("done_valid", out_valid, 1);
    check("out_sum", out_sum, exp[N-1:0]);
    check("out_cout", out_cout, exp[N]);
    check("out_zero", out_zero, exp[N+1]);
    check("out_ovf", out_ovf, exp[N+2]);
    snap_sum = exp[N-1:0];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = N'($urandom);
      in_b     = N'($urandom);
      in_acc   = 1'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      check("hold_sum", {out_ovf, out_zero, out_cout, out_sum}, exp);
      check("hold_add_a", add_a, ea);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("exit_valid", out_valid, 0);
    check("exit_ready", in_ready, 1);
    check("kept_sum", out_sum, snap_sum);
    last_sum  = esum;
    last_cout = ecout;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {add_a, add_b, add_cin, out_sum, out_cout, out_zero, out_ovf, out_valid}, 0);
    check({tag, "_ready"}, in_ready, 0);
  endtask

  // ---------------- main ----------------
  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_cin = 1'b0; in_acc = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ready", in_ready, 1);
    check("post_reset_state", dbg_state, 0);

    do_op(4'b0011, 4'b0101, 0, 0, 0);   // basic add, overflow
    do_op(4'b0111, 4'b1101, 0, 0, 0);   // carry
    do_op(0, 4'b0001, 0, 1, 0);         // accumulate on carry result
    do_op(4'b1000, 4'b1000, 0, 0, 5);   // zero/overflow with back-pressure

    // reset in the middle of CALC
    @(negedge clk);
    in_valid = 1'b1; in_a = 4'b0110; in_b = 4'b0011; in_cin = 1'b1; in_acc = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_state_calc", dbg_state, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_post_ready", in_ready, 1);
    check("mid_post_valid", out_valid, 0);
    @(posedge clk); #1;
    check("mid_no_result", out_valid, 0);
    last_sum  = 0;
    last_cout = 0;

    // randomized operations
    for (int k = 0; k < 40; k++) begin
      do_op($urandom_range(0, (1 << N) - 1), $urandom_range(0, (1 << N) - 1),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // hard time limit
  initial begin
    #200000;
    n_checks++;
    n_errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
